spdif_i2s_rx: RTL and testbench

I2S slave receiver and sample FIFO feeding the S/PDIF transmitter core. It samples an external I2S bus (BCLK, WS, SD) in the `clk_i` domain and assembles 16-bit left/right words into 32-bit frames. Frames are buffered in a small FIFO and presented as a `{right, left}` word that the transmitter consumes via its single-cycle sample request pulse.

---
 rtl/spdif_i2s_rx_if.sv | 24 ++
 rtl/spdif_i2s_rx.sv | 138 +++++++++++++
 tb/tb_spdif_i2s_rx.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spdif_i2s_rx_if.sv
// I2S pins and sample-FIFO handshake between the I2S receiver and the S/PDIF transmitter.
// The slave modport is the receiver side; the master modport is the pin/transmitter side.
interface spdif_i2s_rx_if #(
  parameter int FIFO_DEPTH_W = 3
);
  logic                    i2s_bclk_i;
  logic                    i2s_ws_i;
  logic                    i2s_sd_i;
  logic                    sample_req_i;
  logic [31:0]             sample_o;
  logic [FIFO_DEPTH_W:0]   fifo_level_o;
  logic                    overrun_o;
  logic                    underrun_o;

  modport slave (
    input  i2s_bclk_i, i2s_ws_i, i2s_sd_i, sample_req_i,
    output sample_o, fifo_level_o, overrun_o, underrun_o
  );

  modport master (
    output i2s_bclk_i, i2s_ws_i, i2s_sd_i, sample_req_i,
    input  sample_o, fifo_level_o, overrun_o, underrun_o
  );
endinterface

// File: rtl/spdif_i2s_rx.sv
// I2S slave receiver: assembles 16-bit L/R words into {right, left} frames and buffers them in a FIFO.
// Optional SPDIF_I2S_HOLD_LAST_EN: on underrun repeat the last frame instead of muting.
module spdif_i2s_rx #(
  parameter int FIFO_DEPTH_W = 3
) (
  input  logic            clk_i,
  input  logic            rst_i,
  spdif_i2s_rx_if.slave   bus
);
  localparam int DEPTH = 1 << FIFO_DEPTH_W;
  localparam int PW    = FIFO_DEPTH_W + 1;

  // Input synchronisers; ws/sd get one extra stage so they line up with the registered edge pulse.
  logic [2:0] bclk_sync_reg;
  logic [1:0] ws_sync_reg;
  logic [1:0] sd_sync_reg;
  logic       ws_d_reg;
  logic       sd_d_reg;
  logic       edge_reg;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bclk_sync_reg <= '0;
      ws_sync_reg   <= '0;
      sd_sync_reg   <= '0;
      ws_d_reg      <= 1'b0;
      sd_d_reg      <= 1'b0;
      edge_reg      <= 1'b0;
    end else begin
      bclk_sync_reg <= {bclk_sync_reg[1:0], bus.i2s_bclk_i};
      ws_sync_reg   <= {ws_sync_reg[0], bus.i2s_ws_i};
      sd_sync_reg   <= {sd_sync_reg[0], bus.i2s_sd_i};
      ws_d_reg      <= ws_sync_reg[1];
      sd_d_reg      <= sd_sync_reg[1];
      edge_reg      <= bclk_sync_reg[1] & ~bclk_sync_reg[2];
    end
  end

  logic        ws_last_reg;
  logic [4:0]  bit_cnt_reg;
  logic        chan_reg;
  logic [15:0] shift_reg;
  logic [15:0] left_hold_reg;
  logic        left_valid_reg;
  logic        push_reg;
  logic [31:0] push_data_reg;
  logic [15:0] word_next;

  assign word_next = {shift_reg[14:0], sd_d_reg};

  // bit_cnt parks at 16 so nothing is captured until a WS transition restarts a word.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ws_last_reg    <= 1'b0;
      bit_cnt_reg    <= 5'd16;
      chan_reg       <= 1'b0;
      shift_reg      <= '0;
      left_hold_reg  <= '0;
      left_valid_reg <= 1'b0;
      push_reg       <= 1'b0;
      push_data_reg  <= '0;
    end else begin
      push_reg <= 1'b0;
      if (edge_reg) begin
        if (ws_d_reg != ws_last_reg) begin
          bit_cnt_reg <= 5'd0;
          chan_reg    <= ws_d_reg;
          ws_last_reg <= ws_d_reg;
        end else if (bit_cnt_reg != 5'd16) begin
          shift_reg   <= word_next;
          bit_cnt_reg <= bit_cnt_reg + 5'd1;
          if (bit_cnt_reg == 5'd15) begin
            if (!chan_reg) begin
              left_hold_reg  <= word_next;
              left_valid_reg <= 1'b1;
            end else if (left_valid_reg) begin
              push_reg       <= 1'b1;
              push_data_reg  <= {word_next, left_hold_reg};
              left_valid_reg <= 1'b0;
            end
          end
        end
      end
    end
  end

  logic [31:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [PW-1:0] level;
  logic          full;
  logic          empty;
  logic [31:0]   sample_reg;
  logic          overrun_reg;
  logic          underrun_reg;

  assign level = wr_ptr_reg - rd_ptr_reg;
  assign full  = (level == PW'(DEPTH));
  assign empty = (level == '0);

  always_ff @(posedge clk_i) begin
    if (push_reg && !full) begin
      mem[wr_ptr_reg[FIFO_DEPTH_W-1:0]] <= push_data_reg;
    end
  end

  // Emptiness is judged before this cycle's push, so a pop never bypasses a same-cycle write.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      sample_reg   <= '0;
      overrun_reg  <= 1'b0;
      underrun_reg <= 1'b0;
    end else begin
      overrun_reg  <= push_reg & full;
      underrun_reg <= bus.sample_req_i & empty;
      if (push_reg && !full) begin
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      end
      if (bus.sample_req_i && !empty) begin
        sample_reg <= mem[rd_ptr_reg[FIFO_DEPTH_W-1:0]];
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
      end else if (bus.sample_req_i) begin
`ifdef SPDIF_I2S_HOLD_LAST_EN
        sample_reg <= sample_reg;
`else
        sample_reg <= '0;
`endif
      end
    end
  end

  assign bus.sample_o     = sample_reg;
  assign bus.fifo_level_o = level;
  assign bus.overrun_o    = overrun_reg;
  assign bus.underrun_o   = underrun_reg;
endmodule

// File: tb/tb_spdif_i2s_rx.sv
// Self-checking bench for spdif_i2s_rx: random I2S streams against a frame-level FIFO model.
// Honours SPDIF_I2S_HOLD_LAST_EN for the expected underrun sample.
module tb_spdif_i2s_rx;
  localparam int FIFO_DEPTH_W = 3;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  spdif_i2s_rx_if #(.FIFO_DEPTH_W(FIFO_DEPTH_W)) bus();
  spdif_i2s_rx #(.FIFO_DEPTH_W(FIFO_DEPTH_W)) dut (.clk_i(clk), .rst_i(rst), .bus(bus.slave));

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;
  int ovr_seen = 0;
  int unr_seen = 0;
  int model_ovr = 0;
  int model_unr = 0;
  logic [31:0] model_q[$];
  logic [31:0] last_sample = '0;
  logic [31:0] obs_sample;
  int          obs_level;
  logic        obs_unr;

  always @(posedge clk) begin
    if (bus.overrun_o === 1'b1) ovr_seen++;
    if (bus.underrun_o === 1'b1) unr_seen++;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  // One BCLK period; data changes with the falling edge. With align set, a sample
  // request is placed on the cycle the frame write lands (rise + 4 clk) and the
  // outputs are captured the cycle after.
  task automatic send_bit(input logic ws, input logic sd, input bit align);
    int lo, hi;
    lo = $urandom_range(2, 4);
    hi = $urandom_range(2, 4);
    @(negedge clk);
    bus.i2s_bclk_i = 1'b0; bus.i2s_ws_i = ws; bus.i2s_sd_i = sd;
    repeat (lo) @(negedge clk);
    bus.i2s_bclk_i = 1'b1;
    if (align) begin
      repeat (4) @(negedge clk);
      bus.sample_req_i = 1'b1;
      @(negedge clk);
      bus.sample_req_i = 1'b0;
      obs_sample = bus.sample_o;
      obs_level  = int'(bus.fifo_level_o);
      obs_unr    = bus.underrun_o;
    end else begin
      repeat (hi) @(negedge clk);
    end
  endtask

  // 32-BCLK slot: WS edge bit (previous LSB, ignored), 16 data bits MSB first, 15 padding bits.
  task automatic send_word(input logic ws, input logic [15:0] w, input bit align);
    send_bit(ws, logic'($urandom_range(0, 1)), 1'b0);
    for (int i = 15; i >= 0; i--) send_bit(ws, w[i], align && (i == 0));
    for (int i = 0; i < 15; i++) send_bit(ws, logic'($urandom_range(0, 1)), 1'b0);
  endtask

  task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input bit align);
    send_word(1'b0, l, 1'b0);
    send_word(1'b1, r, align);
    $display("[TB] frame L=%h R=%h", l, r);
  endtask

  task automatic send_preamble();
    int n;
    n = $urandom_range(5, 30);
    for (int i = 0; i < n; i++) send_bit(1'b1, logic'($urandom_range(0, 1)), 1'b0);
  endtask

  task automatic model_push(input logic [31:0] f);
    if (model_q.size() < DEPTH) model_q.push_back(f);
    else model_ovr++;
  endtask

  task automatic model_pop(output logic [31:0] exp_s, output logic exp_u);
    if (model_q.size() > 0) begin
      exp_s = model_q.pop_front();
      exp_u = 1'b0;
    end else begin
      exp_u = 1'b1;
      model_unr++;
`ifdef SPDIF_I2S_HOLD_LAST_EN
      exp_s = last_sample;
`else
      exp_s = 32'h0;
`endif
    end
    last_sample = exp_s;
  endtask

  task automatic do_req();
    @(negedge clk);
    bus.sample_req_i = 1'b1;
    @(negedge clk);
    bus.sample_req_i = 1'b0;
    $display("[TB] request sample=%h level=%0d", bus.sample_o, bus.fifo_level_o);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_q.delete();
    last_sample = '0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    tests_run++; if (bus.sample_o !== 32'h0) begin tests_failed++; $display("FAIL reset_sample: got %h expected 0", bus.sample_o); end
    tests_run++; if (bus.fifo_level_o !== '0) begin tests_failed++; $display("FAIL reset_level: got %0d expected 0", bus.fifo_level_o); end
    tests_run++; if (bus.overrun_o !== 1'b0) begin tests_failed++; $display("FAIL reset_overrun: got %b expected 0", bus.overrun_o); end
    tests_run++; if (bus.underrun_o !== 1'b0) begin tests_failed++; $display("FAIL reset_underrun: got %b expected 0", bus.underrun_o); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [31:0] es; logic eu;
    send_preamble();
    tests_run++; if (int'(bus.fifo_level_o) !== 0) begin tests_failed++; $display("FAIL basic_level_pre: got %0d expected 0", bus.fifo_level_o); end
    send_frame(16'h1234, 16'hABCD, 1'b0);
    model_push(32'hABCD_1234);
    tests_run++; if (int'(bus.fifo_level_o) !== model_q.size()) begin tests_failed++; $display("FAIL basic_level_push: got %0d expected %0d", bus.fifo_level_o, model_q.size()); end
    model_pop(es, eu);
    do_req();
    tests_run++; if (bus.sample_o !== es) begin tests_failed++; $display("FAIL basic_sample: got %h expected %h", bus.sample_o, es); end
    tests_run++; if (int'(bus.fifo_level_o) !== model_q.size()) begin tests_failed++; $display("FAIL basic_level_pop: got %0d expected %0d", bus.fifo_level_o, model_q.size()); end
  endtask

  task automatic test_partial_first();
    logic [31:0] es; logic eu;
    bus.i2s_ws_i = 1'b1;
    apply_reset();
    send_preamble();
    send_frame(16'h0001, 16'h0002, 1'b0);
    model_push(32'h0002_0001);
    tests_run++; if (int'(bus.fifo_level_o) !== 1) begin tests_failed++; $display("FAIL partial_level: got %0d expected 1", bus.fifo_level_o); end
    model_pop(es, eu);
    do_req();
    tests_run++; if (bus.sample_o !== es) begin tests_failed++; $display("FAIL partial_sample: got %h expected %h", bus.sample_o, es); end
  endtask

  task automatic test_overrun();
    logic [31:0] es; logic eu;
    for (int i = 0; i < DEPTH; i++) begin
      logic [31:0] f;
      f = $urandom;
      send_frame(f[15:0], f[31:16], 1'b0);
      model_push(f);
    end
    tests_run++; if (ovr_seen !== model_ovr) begin tests_failed++; $display("FAIL overrun_none: got %0d pulses expected %0d", ovr_seen, model_ovr); end
    send_frame(16'hDEAD, 16'hBEEF, 1'b0);
    model_push(32'hBEEF_DEAD);
    tests_run++; if (int'(bus.fifo_level_o) !== DEPTH) begin tests_failed++; $display("FAIL overrun_level: got %0d expected %0d", bus.fifo_level_o, DEPTH); end
    tests_run++; if (ovr_seen !== model_ovr) begin tests_failed++; $display("FAIL overrun_pulse: got %0d pulses expected %0d", ovr_seen, model_ovr); end
    for (int i = 0; i < DEPTH; i++) begin
      model_pop(es, eu);
      do_req();
      tests_run++; if (bus.sample_o !== es) begin tests_failed++; $display("FAIL overrun_drain%0d: got %h expected %h", i, bus.sample_o, es); end
    end
  endtask

  task automatic test_underrun();
    logic [31:0] es; logic eu;
    send_frame(16'hAAAA, 16'h5555, 1'b0);
    model_push(32'h5555_AAAA);
    model_pop(es, eu);
    do_req();
    tests_run++; if (bus.sample_o !== es) begin tests_failed++; $display("FAIL underrun_setup: got %h expected %h", bus.sample_o, es); end
    model_pop(es, eu);
    do_req();
    tests_run++; if (bus.underrun_o !== eu) begin tests_failed++; $display("FAIL underrun_pulse: got %b expected %b", bus.underrun_o, eu); end
    tests_run++; if (bus.sample_o !== es) begin tests_failed++; $display("FAIL underrun_sample: got %h expected %h", bus.sample_o, es); end
    @(negedge clk);
    tests_run++; if (bus.underrun_o !== 1'b0) begin tests_failed++; $display("FAIL underrun_width: got %b expected 0", bus.underrun_o); end
    tests_run++; if (unr_seen !== model_unr) begin tests_failed++; $display("FAIL underrun_count: got %0d expected %0d", unr_seen, model_unr); end
  endtask

  task automatic test_push_pop();
    logic [31:0] es; logic eu;
    send_frame(16'h1111, 16'h2222, 1'b0);
    model_push(32'h2222_1111);
    send_frame(16'h3333, 16'h4444, 1'b1);
    model_pop(es, eu);
    model_push(32'h4444_3333);
    tests_run++; if (obs_level !== model_q.size()) begin tests_failed++; $display("FAIL pushpop1_level: got %0d expected %0d", obs_level, model_q.size()); end
    tests_run++; if (obs_sample !== es) begin tests_failed++; $display("FAIL pushpop1_sample: got %h expected %h", obs_sample, es); end
    tests_run++; if (obs_unr !== eu) begin tests_failed++; $display("FAIL pushpop1_underrun: got %b expected %b", obs_unr, eu); end
    model_pop(es, eu);
    do_req();
    tests_run++; if (bus.sample_o !== es) begin tests_failed++; $display("FAIL pushpop_drain: got %h expected %h", bus.sample_o, es); end
    send_frame(16'h5A5A, 16'hA5A5, 1'b1);
    model_pop(es, eu);
    model_push(32'hA5A5_5A5A);
    tests_run++; if (obs_level !== model_q.size()) begin tests_failed++; $display("FAIL pushpop0_level: got %0d expected %0d", obs_level, model_q.size()); end
    tests_run++; if (obs_sample !== es) begin tests_failed++; $display("FAIL pushpop0_sample: got %h expected %h", obs_sample, es); end
    tests_run++; if (obs_unr !== eu) begin tests_failed++; $display("FAIL pushpop0_underrun: got %b expected %b", obs_unr, eu); end
    model_pop(es, eu);
    do_req();
    tests_run++; if (bus.sample_o !== es) begin tests_failed++; $display("FAIL pushpop0_stored: got %h expected %h", bus.sample_o, es); end
  endtask

  task automatic test_reset_mid_word();
    logic [31:0] es; logic eu; logic [15:0] l;
    send_frame(16'h0F0F, 16'hF0F0, 1'b0);
    model_push(32'hF0F0_0F0F);
    l = 16'($urandom);
    send_bit(1'b0, 1'b0, 1'b0);
    for (int i = 15; i >= 8; i--) send_bit(1'b0, l[i], 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    tests_run++; if (bus.sample_o !== 32'h0) begin tests_failed++; $display("FAIL rstmid_sample: got %h expected 0", bus.sample_o); end
    tests_run++; if (bus.fifo_level_o !== '0) begin tests_failed++; $display("FAIL rstmid_level: got %0d expected 0", bus.fifo_level_o); end
    tests_run++; if (bus.overrun_o !== 1'b0 || bus.underrun_o !== 1'b0) begin tests_failed++; $display("FAIL rstmid_flags: got %b%b expected 00", bus.overrun_o, bus.underrun_o); end
    rst = 1'b0;
    model_q.delete();
    last_sample = '0;
    for (int i = 7; i >= 0; i--) send_bit(1'b0, l[i], 1'b0);
    for (int i = 0; i < 15; i++) send_bit(1'b0, 1'b1, 1'b0);
    send_word(1'b1, 16'h7777, 1'b0);
    tests_run++; if (int'(bus.fifo_level_o) !== model_q.size()) begin tests_failed++; $display("FAIL rstmid_discard: got %0d expected %0d", bus.fifo_level_o, model_q.size()); end
    send_frame(16'h1357, 16'h2468, 1'b0);
    model_push(32'h2468_1357);
    tests_run++; if (int'(bus.fifo_level_o) !== model_q.size()) begin tests_failed++; $display("FAIL rstmid_resume: got %0d expected %0d", bus.fifo_level_o, model_q.size()); end
    model_pop(es, eu);
    do_req();
    tests_run++; if (bus.sample_o !== es) begin tests_failed++; $display("FAIL rstmid_sample2: got %h expected %h", bus.sample_o, es); end
  endtask

  task automatic test_random_stream();
    logic [31:0] es; logic eu;
    for (int it = 0; it < 6; it++) begin
      int nf, np;
      nf = $urandom_range(1, 3);
      np = $urandom_range(1, 4);
      for (int k = 0; k < nf; k++) begin
        logic [31:0] f;
        f = $urandom;
        send_frame(f[15:0], f[31:16], 1'b0);
        model_push(f);
      end
      tests_run++; if (int'(bus.fifo_level_o) !== model_q.size()) begin tests_failed++; $display("FAIL rand_level%0d: got %0d expected %0d", it, bus.fifo_level_o, model_q.size()); end
      for (int k = 0; k < np; k++) begin
        model_pop(es, eu);
        do_req();
        tests_run++; if (bus.sample_o !== es || bus.underrun_o !== eu) begin tests_failed++; $display("FAIL rand_pop%0d_%0d: got %h/%b expected %h/%b", it, k, bus.sample_o, bus.underrun_o, es, eu); end
      end
    end
    repeat (2) @(negedge clk);
    tests_run++; if (ovr_seen !== model_ovr) begin tests_failed++; $display("FAIL rand_overruns: got %0d expected %0d", ovr_seen, model_ovr); end
    tests_run++; if (unr_seen !== model_unr) begin tests_failed++; $display("FAIL rand_underruns: got %0d expected %0d", unr_seen, model_unr); end
  endtask

  initial begin
    bus.i2s_bclk_i   = 1'b0;
    bus.i2s_ws_i     = 1'b0;
    bus.i2s_sd_i     = 1'b0;
    bus.sample_req_i = 1'b0;
    rst = 1'b1;
    test_reset();
    test_basic();
    test_partial_first();
    test_overrun();
    test_underrun();
    test_push_pop();
    test_reset_mid_word();
    test_random_stream();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
